// File: rtl/ascii_uart_tx.sv
// ascii_uart_tx: FIFO-buffered UART transmitter for ASCII bytes, 8N1 LSB first.
// Define UART_TX_PARITY_EN for 8E1 framing (even parity bit before stop).
module ascii_uart_tx #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [7:0]                  data_in,
   input  logic                        data_valid,
   output logic                        data_ready,
   output logic                        tx,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [15:0] DIV_M1 = 16'(CLK_DIV - 1);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [7:0]  mem_d [FIFO_DEPTH];
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        full, empty, push, pop;
   logic [7:0]  head;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        tick;
`ifdef UART_TX_PARITY_EN
   logic        par_q, par_d;
`endif

   // Pointers carry one extra wrap bit so full and empty differ.
   assign empty      = (wr_ptr_q == rd_ptr_q);
   assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign push       = data_valid & ~full;
   assign head       = mem_q[rd_ptr_q[AW-1:0]];
   assign data_ready = ~full;
   assign fifo_level = wr_ptr_q - rd_ptr_q;
   assign tick       = (cnt_q == 16'd0);
   assign tx         = tx_q;
   assign busy       = busy_q;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         mem_d[wr_ptr_q[AW-1:0]] = data_in;
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d     = par_q;
`endif
      if (state_q != IDLE && !tick) begin
         cnt_d = cnt_q - 16'd1;
      end
      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            pop  = ~empty;
         end
         START: begin
            if (tick) begin
               state_d   = DATA;
               cnt_d     = DIV_M1;
               bit_idx_d = 3'd0;
               tx_d      = shift_q[0];
            end
         end
         DATA: begin
            if (tick) begin
               cnt_d = DIV_M1;
               if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = par_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               state_d = STOP;
               cnt_d   = DIV_M1;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            if (tick) begin
               cnt_d = DIV_M1;
               if (!empty) begin
                  pop = 1'b1;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
      // Loading the next byte from IDLE or from the end of STOP is the same.
      if (pop) begin
         state_d = START;
         shift_d = head;
         cnt_d   = DIV_M1;
         tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
         par_d   = ^head;
`endif
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         state_q   <= IDLE;
         cnt_q     <= 16'd0;
         bit_idx_q <= 3'd0;
         shift_q   <= 8'h00;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_ascii_uart_tx.sv
// Testbench for ascii_uart_tx: random and fixed bytes checked against a frame model.
// Build with UART_TX_PARITY_EN defined to exercise 8E1 framing.
module tb_ascii_uart_tx;

   localparam int DIV   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int F    = (10 + PAR) * DIV;
   localparam int FMAX = 11 * DIV;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       data_valid = 1'b0;
   logic       data_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_level;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] a_byte;
   logic [7:0] fb [4];

   ascii_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk),
      .reset(reset),
      .data_in(data_in),
      .data_valid(data_valid),
      .data_ready(data_ready),
      .tx(tx),
      .busy(busy),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   // Expected tx waveform, one entry per clock, for a whole frame.
   function automatic logic [FMAX-1:0] wave(input logic [7:0] b);
      logic [FMAX-1:0] w;
      int n;
      w = '1;
      for (int k = 0; k < F; k++) begin
         n = k / DIV;
         if (n == 0) w[k] = 1'b0;
         else if (n <= 8) w[k] = b[3'(n - 1)];
         else if (PAR != 0 && n == 9) w[k] = ^b;
         else w[k] = 1'b1;
      end
      return w;
   endfunction

   task automatic grab(output logic [FMAX-1:0] w, output int bc);
      w = '1;
      bc = 0;
      for (int k = 0; k < F; k++) begin
         @(posedge clk);
         @(negedge clk);
         w[k] = tx;
         bc += int'(busy);
      end
   endtask

   // Push a_byte, then fb[0..n-1] back to back; stop at the negedge
   // just before the edge that ends a_byte's stop bit.
   task automatic goto_stop_end(input int n);
      @(negedge clk);
      data_valid = 1'b1;
      data_in = a_byte;
      @(posedge clk);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         data_in = fb[i];
         @(posedge clk);
      end
      @(negedge clk);
      data_valid = 1'b0;
      repeat (F - n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      int guard;
      guard = 0;
      while (busy !== 1'b0 && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_drain: busy got %b want 0", tag, busy);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      data_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (tx !== 1'b1) begin
         n_fail++; $display("FAIL reset_tx: got %b want 1", tx);
      end
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
      end
      n_checks++;
      if (data_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_ready: got %b want 1", data_ready);
      end
      n_checks++;
      if (fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL post_reset_idle: tx %b busy %b want 1 0", tx, busy);
      end
   endtask

   task automatic test_single_byte();
      logic [7:0] b;
      logic [FMAX-1:0] w;
      int bc;
      for (int t = 0; t < 4; t++) begin
         b = (t == 0) ? 8'h47 : 8'($urandom);
         @(negedge clk);
         data_valid = 1'b1;
         data_in = b;
         @(posedge clk);
         @(negedge clk);
         data_valid = 1'b0;
         n_checks++;
         if (busy !== 1'b0 || tx !== 1'b1 || fifo_level !== 3'd1) begin
            n_fail++;
            $display("FAIL single_push_edge: busy %b tx %b lvl %0d want 0 1 1",
                     busy, tx, fifo_level);
         end
         grab(w, bc);
         n_checks++;
         if (w !== wave(b)) begin
            n_fail++;
            $display("FAIL single_frame: byte %h got %h want %h", b, w, wave(b));
         end
         n_checks++;
         if (bc != F) begin
            n_fail++; $display("FAIL single_busy_len: got %0d want %0d", bc, F);
         end
         @(posedge clk);
         @(negedge clk);
         n_checks++;
         if (busy !== 1'b0 || tx !== 1'b1) begin
            n_fail++; $display("FAIL single_idle: busy %b tx %b want 0 1", busy, tx);
         end
      end
   endtask

   task automatic test_stream();
      logic [7:0] s [9] = '{8'h47, 8'h75, 8'h61, 8'h74, 8'h65,
                            8'h6D, 8'h61, 8'h6C, 8'h61};
      logic [FMAX-1:0] fr [9];
      int bc, idx, guard, drop_idx;
      logic rdy;
      logic [2:0] drop_lvl;
      idx = 0;
      guard = 0;
      drop_idx = -1;
      drop_lvl = 3'd0;
      fork
         begin
            while (idx < 9 && guard < 2000) begin
               @(negedge clk);
               data_valid = 1'b1;
               data_in = s[idx];
               rdy = data_ready;
               if (!rdy && drop_idx < 0) begin
                  drop_idx = idx;
                  drop_lvl = fifo_level;
               end
               @(posedge clk);
               if (rdy) idx++;
               guard++;
            end
            @(negedge clk);
            data_valid = 1'b0;
         end
         begin
            @(negedge clk);
            @(posedge clk);
            for (int i = 0; i < 9; i++) grab(fr[i], bc);
         end
      join
      n_checks++;
      if (idx != 9) begin
         n_fail++; $display("FAIL stream_accepted: got %0d want 9", idx);
      end
      n_checks++;
      if (drop_idx != 5 || drop_lvl !== 3'd4) begin
         n_fail++;
         $display("FAIL stream_ready_drop: at byte %0d lvl %0d want 5 4", drop_idx, drop_lvl);
      end
      for (int i = 0; i < 9; i++) begin
         n_checks++;
         if (fr[i] !== wave(s[i])) begin
            n_fail++;
            $display("FAIL stream_frame%0d: got %h want %h", i, fr[i], wave(s[i]));
         end
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         n_fail++; $display("FAIL stream_idle: busy %b tx %b want 0 1", busy, tx);
      end
   endtask

   task automatic test_full_boundary();
      logic [7:0] x;
      logic [FMAX-1:0] fr [5];
      logic [7:0] ex [5];
      int bc;
      a_byte = 8'($urandom);
      for (int i = 0; i < 4; i++) fb[i] = 8'($urandom);
      x = 8'($urandom);
      goto_stop_end(4);
      n_checks++;
      if (fifo_level !== 3'd4 || data_ready !== 1'b0 || tx !== 1'b1) begin
         n_fail++;
         $display("FAIL full_pre: lvl %0d ready %b tx %b want 4 0 1",
                  fifo_level, data_ready, tx);
      end
      data_valid = 1'b1;
      data_in = x;
      fork
         begin
            for (int i = 0; i < 5; i++) grab(fr[i], bc);
         end
         begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (fifo_level !== 3'd3 || data_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL full_pop_edge: lvl %0d ready %b want 3 1",
                        fifo_level, data_ready);
            end
            @(posedge clk);
            @(negedge clk);
            data_valid = 1'b0;
            n_checks++;
            if (fifo_level !== 3'd4) begin
               n_fail++; $display("FAIL full_accept: lvl got %0d want 4", fifo_level);
            end
         end
      join
      ex = '{fb[0], fb[1], fb[2], fb[3], x};
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (fr[i] !== wave(ex[i])) begin
            n_fail++;
            $display("FAIL full_frame%0d: got %h want %h", i, fr[i], wave(ex[i]));
         end
      end
      wait_idle("full");
   endtask

   task automatic test_simul_push_pop();
      logic [7:0] x;
      logic [FMAX-1:0] fr [3];
      logic [7:0] ex [3];
      int bc;
      a_byte = 8'($urandom);
      fb[0] = 8'($urandom);
      fb[1] = 8'($urandom);
      x = 8'($urandom);
      goto_stop_end(2);
      n_checks++;
      if (fifo_level !== 3'd2 || data_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_pre: lvl %0d ready %b want 2 1", fifo_level, data_ready);
      end
      data_valid = 1'b1;
      data_in = x;
      fork
         begin
            for (int i = 0; i < 3; i++) grab(fr[i], bc);
         end
         begin
            @(posedge clk);
            @(negedge clk);
            data_valid = 1'b0;
            n_checks++;
            if (fifo_level !== 3'd2) begin
               n_fail++; $display("FAIL simul_level: got %0d want 2", fifo_level);
            end
         end
      join
      ex = '{fb[0], fb[1], x};
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (fr[i] !== wave(ex[i])) begin
            n_fail++;
            $display("FAIL simul_frame%0d: got %h want %h", i, fr[i], wave(ex[i]));
         end
      end
      wait_idle("simul");
   endtask

   task automatic test_reset_mid_frame();
      logic [FMAX-1:0] w;
      int bc;
      @(negedge clk);
      data_valid = 1'b1;
      data_in = 8'h51;
      @(posedge clk);
      @(negedge clk);
      data_in = 8'h33;
      @(posedge clk);
      @(negedge clk);
      data_valid = 1'b0;
      repeat (17) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (tx !== 1'b0 || fifo_level !== 3'd1) begin
         n_fail++;
         $display("FAIL midframe_bit3: tx %b lvl %0d want 0 1", tx, fifo_level);
      end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (tx !== 1'b1 || busy !== 1'b0) begin
         n_fail++; $display("FAIL midframe_async: tx %b busy %b want 1 0", tx, busy);
      end
      n_checks++;
      if (fifo_level !== 3'd0 || data_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_fifo: lvl %0d ready %b want 0 1", fifo_level, data_ready);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      data_valid = 1'b1;
      data_in = 8'h7A;
      @(posedge clk);
      @(negedge clk);
      data_valid = 1'b0;
      grab(w, bc);
      n_checks++;
      if (w !== wave(8'h7A)) begin
         n_fail++; $display("FAIL midframe_7a: got %h want %h", w, wave(8'h7A));
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || tx !== 1'b1 || fifo_level !== 3'd0) begin
         n_fail++;
         $display("FAIL midframe_after: busy %b tx %b lvl %0d want 0 1 0",
                  busy, tx, fifo_level);
      end
   endtask

`ifdef UART_TX_PARITY_EN
   task automatic test_parity();
      logic [FMAX-1:0] fr [2];
      int bc;
      @(negedge clk);
      data_valid = 1'b1;
      data_in = 8'h51;
      @(posedge clk);
      @(negedge clk);
      data_in = 8'h47;
      fork
         begin
            grab(fr[0], bc);
            grab(fr[1], bc);
         end
         begin
            @(posedge clk);
            @(negedge clk);
            data_valid = 1'b0;
         end
      join
      n_checks++;
      if (fr[0][9*DIV+1] !== 1'b1) begin
         n_fail++; $display("FAIL parity_51: got %b want 1", fr[0][9*DIV+1]);
      end
      n_checks++;
      if (fr[1][9*DIV+1] !== 1'b0) begin
         n_fail++; $display("FAIL parity_47: got %b want 0", fr[1][9*DIV+1]);
      end
      n_checks++;
      if (fr[0] !== wave(8'h51) || fr[1] !== wave(8'h47)) begin
         n_fail++;
         $display("FAIL parity_frames: got %h %h want %h %h",
                  fr[0], fr[1], wave(8'h51), wave(8'h47));
      end
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
         n_fail++; $display("FAIL parity_idle: busy %b tx %b want 0 1", busy, tx);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single_byte();
      test_stream();
      test_full_boundary();
      test_simul_push_pop();
      test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
